spi_mem_emu: RTL and testbench
==============================

// Module: spi_mem_emu
// PURPOSE
//  Synthesisable, clk-synchronous SPI (mode 0) memory slave emulating the off-chip flash/RAM used by the CPU bus.
//  Oversamples SCK/MOSI/CE_N on the system clock; parametrised in address width, depth, read-only mode and fast-read.
//  Sits on the SPI pins (SCK/MOSI/CE_N in, MISO out) in benches and FPGA bring-up; a backdoor port preloads contents.
// PARAMETERS
//  ADDR_BYTES   2     address bytes sent after the command (1..3)
//  DEPTH        4096  memory size in bytes; addresses taken modulo DEPTH
//  IS_FLASH     0     1: WRITE (0x02) accepted but discarded (read-only)
//  DUMMY_BITS   8     dummy SCK cycles after address for FAST_READ (0x0B)
// PORTS
//  clk        in   1   system clock; must be >= 4x spi_sck frequency
//  rst        in   1   asynchronous, active-high reset
//  spi_sck    in   1   SPI clock (asynchronous to clk)
//  spi_mosi   in   1   master-out data
//  spi_ce_n   in   1   chip enable, active low
//  spi_miso   out  1   slave-out data, registered
//  load_en    in   1   backdoor write strobe
//  load_addr  in   A   backdoor address, A = clog2(DEPTH)
//  load_data  in   8   backdoor write data
//  busy       out  1   1 while a transaction is active (CE low, not IDLE)
//  last_cmd   out  8   command byte of the most recent transaction
// BEHAVIOUR
//  - Reset: spi_miso=0, busy=0, last_cmd=0x00, state=IDLE, address/shift/bit counters=0; memory NOT cleared.
//  - Inputs pass through 2-flop synchronisers; rise/fall detected on synced SCK; all logic is clocked by clk.
//  - Mode 0: MOSI sampled at SCK rise; MISO changes at SCK fall. MISO updates <=3 clk after the SCK fall.
//  - Bits are MSB first; address is big-endian across ADDR_BYTES.
//  - States: IDLE -> CMD (CE_N falls) -> ADDR (8 bits in) -> [DUMMY] -> READ | WRITE; any unknown cmd -> IGNORE.
//    0x03 READ: ADDR -> READ. 0x0B FAST_READ: ADDR -> DUMMY (DUMMY_BITS rises) -> READ. 0x02 WRITE: ADDR -> WRITE.
//  - CE_N rising (synced) in ANY state -> IDLE next clk; partial bytes discarded; spi_miso -> 0; busy -> 0.
//  - READ: byte at addr loaded into the shift register one clk after the last addr/dummy bit; its MSB is driven
//    on the following SCK fall; after each 8th bit addr <= (addr+1) mod DEPTH and next byte is fetched.
//  - WRITE: each complete byte written to mem[addr] one clk after its 8th rise; then addr increments with wrap.
//    IS_FLASH=1: bytes are shifted and counted but never written.
//  - IGNORE: MOSI consumed, spi_miso held 0, until CE_N rises.
//  - spi_miso=0 whenever state is not READ.
//  - last_cmd updated on the 8th CMD bit; held through IDLE.
//  - load_en: mem[load_addr]<=load_data at clk edge, any state. Same-cycle SPI write to same address: backdoor wins.
//  - Address bits beyond clog2(DEPTH) are ignored (modulo DEPTH).
//  - SCK toggling while CE_N high: no effect. CE_N low with no SCK: stays in CMD.
//  - rst asserted mid-transaction: immediate return to reset values; after rst drops, a new transaction starts
//    only on a fresh CE_N falling edge.
// TESTING
//  1. Preload 0x0010..0x0013 = A5 5A 01 FF; READ 03 00 10, 32 clocks -> MISO bytes A5 5A 01 FF; last_cmd=0x03.
//  2. DEPTH=4096, preload 0x0FFF=0x11, 0x0000=0x22; READ from 0x0FFF, 2 bytes -> 11 22 (wrap).
//  3. IS_FLASH=0: WRITE 02 01 00 DE AD, then READ 03 01 00 -> DE AD.
//     IS_FLASH=1: same sequence -> original preloaded bytes.
//  4. FAST_READ 0B 00 10 + 8 dummy cycles -> A5; MISO=0 during all dummy cycles.
//  5. CE_N raised after 4 data bits of a WRITE -> target byte unchanged, busy=0 within 3 clk;
//     next READ is correct. Unknown cmd 0x9F -> MISO=0 throughout.
//  6. rst pulsed mid-READ -> spi_miso=0, busy=0, last_cmd=0x00 asynchronously; the next full READ returns
//     correct data. Sweep the SCK:clk ratio at 1:4 and 1:16.

Source files
------------

// File: rtl/spi_mem_emu.sv
// spi_mem_emu: clk-synchronous SPI mode-0 memory slave with a backdoor preload port.
// SCK, MOSI and CE_N are oversampled on clk. The slave accepts READ (0x03),
// FAST_READ (0x0B) and WRITE (0x02); any other command is ignored until CE_N rises.
// Ports:
//   clk, rst                 system clock, asynchronous active-high reset
//   spi_sck/mosi/ce_n        SPI inputs (asynchronous to clk)
//   spi_miso                 registered slave-out data, 0 outside READ
//   load_en/addr/data        backdoor byte write, any state
//   busy                     transaction in progress
//   last_cmd                 command byte of the most recent transaction
module spi_mem_emu #(
  parameter int unsigned ADDR_BYTES = 2,
  parameter int unsigned DEPTH      = 4096,
  parameter int unsigned IS_FLASH   = 0,
  parameter int unsigned DUMMY_BITS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     spi_sck,
  input  logic                     spi_mosi,
  input  logic                     spi_ce_n,
  output logic                     spi_miso,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [7:0]               load_data,
  output logic                     busy,
  output logic [7:0]               last_cmd
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned ADDR_BITS = ADDR_BYTES * 8;
  localparam int unsigned CNT_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_READ, ST_WRITE, ST_IGNORE
  } state_e;

  typedef enum logic [1:0] {
    OP_READ, OP_FAST, OP_WRITE
  } op_e;

  logic [7:0] mem [DEPTH];

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  logic [2:0]           sck_sync_q, sck_sync_d;
  logic [2:0]           ce_sync_q, ce_sync_d;
  logic [1:0]           mosi_sync_q, mosi_sync_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic [ADDR_BITS-1:0] addr_sr_q, addr_sr_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic                 fetch_q, fetch_d;
  logic                 wr_pend_q, wr_pend_d;
  logic [7:0]           wr_data_q, wr_data_d;
  logic                 miso_q, miso_d;
  logic                 busy_q, busy_d;
  logic [7:0]           last_cmd_q, last_cmd_d;

  logic                 sck_rise, sck_fall, ce_fall, ce_rise, mosi_s;
  logic [7:0]           byte_in;
  logic [ADDR_BITS-1:0] addr_full;
  logic [AW-1:0]        addr_mod, addr_inc;

  // Edge detection on synchronised pins; MOSI shares the SCK sync depth so it lines up with rises.
  assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
  assign ce_fall  = ~ce_sync_q[1] & ce_sync_q[2];
  assign ce_rise  = ce_sync_q[1] & ~ce_sync_q[2];
  assign mosi_s   = mosi_sync_q[1];

  assign byte_in   = {shift_q[6:0], mosi_s};
  assign addr_full = {addr_sr_q[ADDR_BITS-2:0], mosi_s};
  assign addr_mod  = AW'(32'(addr_full) % 32'(DEPTH));
  assign addr_inc  = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);

  // Next-state and datapath.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    sck_sync_d  = {sck_sync_q[1:0], spi_sck};
    ce_sync_d   = {ce_sync_q[1:0], spi_ce_n};
    mosi_sync_d = {mosi_sync_q[0], spi_mosi};
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    addr_sr_d   = addr_sr_q;
    addr_d      = addr_q;
    fetch_d     = 1'b0;
    wr_pend_d   = 1'b0;
    wr_data_d   = wr_data_q;
    miso_d      = miso_q;
    last_cmd_d  = last_cmd_q;

    // Read fetch lands one clk after the byte boundary; write-back bumps the address.
    if (fetch_q) shift_d = mem[addr_q];
    if (wr_pend_q) addr_d = addr_inc;

    unique case (state_q)
      ST_IDLE: begin
        if (ce_fall) begin
          state_d   = ST_CMD;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      ST_CMD: begin
        if (sck_rise) begin
          shift_d = byte_in;
          if (bit_cnt_q == CNT_W'(7)) begin
            bit_cnt_d  = '0;
            last_cmd_d = byte_in;
            addr_sr_d  = '0;
            unique case (byte_in)
              8'h03:   begin op_d = OP_READ;  state_d = ST_ADDR; end
              8'h0B:   begin op_d = OP_FAST;  state_d = ST_ADDR; end
              8'h02:   begin op_d = OP_WRITE; state_d = ST_ADDR; end
              default: state_d = ST_IGNORE;
            endcase
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_ADDR: begin
        if (sck_rise) begin
          addr_sr_d = addr_full;
          if (bit_cnt_q == CNT_W'(ADDR_BITS - 1)) begin
            bit_cnt_d = '0;
            addr_d    = addr_mod;
            unique case (op_q)
              OP_WRITE: begin
                state_d = ST_WRITE;
                shift_d = '0;
              end
              OP_FAST: begin
                if (DUMMY_BITS == 0) begin
                  state_d = ST_READ;
                  fetch_d = 1'b1;
                end else begin
                  state_d = ST_DUMMY;
                end
              end
              default: begin
                state_d = ST_READ;
                fetch_d = 1'b1;
              end
            endcase
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DUMMY: begin
        if (sck_rise) begin
          if (bit_cnt_q == CNT_W'(DUMMY_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = ST_READ;
            fetch_d   = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_READ: begin
        // Each fall presents the next bit; after the 8th, advance and prefetch.
        if (sck_fall) begin
          miso_d  = shift_q[7];
          shift_d = {shift_q[6:0], 1'b0};
          if (bit_cnt_q == CNT_W'(7)) begin
            bit_cnt_d = '0;
            addr_d    = addr_inc;
            fetch_d   = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_WRITE: begin
        if (sck_rise) begin
          shift_d = byte_in;
          if (bit_cnt_q == CNT_W'(7)) begin
            bit_cnt_d = '0;
            wr_data_d = byte_in;
            wr_pend_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase

    // CE_N release aborts everything, including any partial byte.
    if (ce_rise) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      fetch_d   = 1'b0;
    end

    if (state_d != ST_READ) miso_d = 1'b0;
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers. CE sync resets low so a CE_N held low
  // through reset is not mistaken for a new falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_READ;
      sck_sync_q  <= '0;
      ce_sync_q   <= '0;
      mosi_sync_q <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      addr_sr_q   <= '0;
      addr_q      <= '0;
      fetch_q     <= 1'b0;
      wr_pend_q   <= 1'b0;
      wr_data_q   <= '0;
      miso_q      <= 1'b0;
      busy_q      <= 1'b0;
      last_cmd_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      sck_sync_q  <= sck_sync_d;
      ce_sync_q   <= ce_sync_d;
      mosi_sync_q <= mosi_sync_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      addr_sr_q   <= addr_sr_d;
      addr_q      <= addr_d;
      fetch_q     <= fetch_d;
      wr_pend_q   <= wr_pend_d;
      wr_data_q   <= wr_data_d;
      miso_q      <= miso_d;
      busy_q      <= busy_d;
      last_cmd_q  <= last_cmd_d;
    end
  end

  // Memory array; not reset. Backdoor write is ordered last so it wins on a collision.
  always_ff @(posedge clk) begin
    if (wr_pend_q && (IS_FLASH == 0)) mem[addr_q] <= wr_data_q;
    if (load_en) mem[load_addr] <= load_data;
  end

  assign spi_miso = miso_q;
  assign busy     = busy_q;
  assign last_cmd = last_cmd_q;

endmodule

// File: tb/tb_spi_mem_emu.sv
// tb_spi_mem_emu: directed bench driving a RAM (IS_FLASH=0) and a flash (IS_FLASH=1)
// instance from one SPI master; each instance has its own outputs.
module tb_spi_mem_emu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sck = 1'b0;
  logic        mosi = 1'b0;
  logic        ce_n = 1'b1;
  logic        load_en = 1'b0;
  logic [11:0] load_addr = '0;
  logic [7:0]  load_data = '0;
  logic        miso_r, miso_f, busy_r, busy_f;
  logic [7:0]  last_r, last_f;

  int checks = 0;
  int failures = 0;
  int hp = 2;  // SCK half period in clk cycles

  logic [7:0] tx_q [$];
  logic [7:0] rr_q [$];
  logic [7:0] rf_q [$];

  always #5 clk = ~clk;

  spi_mem_emu #(.ADDR_BYTES(2), .DEPTH(4096), .IS_FLASH(0), .DUMMY_BITS(8)) u_ram (
    .clk(clk), .rst(rst), .spi_sck(sck), .spi_mosi(mosi), .spi_ce_n(ce_n),
    .spi_miso(miso_r), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .busy(busy_r), .last_cmd(last_r));

  spi_mem_emu #(.ADDR_BYTES(2), .DEPTH(4096), .IS_FLASH(1), .DUMMY_BITS(8)) u_flash (
    .clk(clk), .rst(rst), .spi_sck(sck), .spi_mosi(mosi), .spi_ce_n(ce_n),
    .spi_miso(miso_f), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .busy(busy_f), .last_cmd(last_f));

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [11:0] a, input logic [7:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    clks(1);
    load_en = 1'b0;
  endtask

  // One bit: MOSI set, SCK high, MISO sampled at the end of the high phase, SCK low.
  task automatic xbit(input logic b, output logic sr, output logic sf);
    mosi = b;
    clks(hp);
    sck = 1'b1;
    clks(hp);
    sr = miso_r;
    sf = miso_f;
    sck = 1'b0;
  endtask

  task automatic xbyte(input logic [7:0] tx, output logic [7:0] rr, output logic [7:0] rf);
    logic sr, sf;
    for (int i = 7; i >= 0; i--) begin
      xbit(tx[i], sr, sf);
      rr[i] = sr;
      rf[i] = sf;
    end
  endtask

  task automatic cs_on();
    ce_n = 1'b0;
    clks(4);
  endtask

  task automatic cs_off();
    clks(hp);
    ce_n = 1'b1;
    clks(4);
  endtask

  task automatic put(input logic [7:0] b);
    tx_q.push_back(b);
  endtask

  task automatic put_hdr(input logic [7:0] cmd, input logic [15:0] a);
    put(cmd); put(a[15:8]); put(a[7:0]);
  endtask

  task automatic run_txn();
    logic [7:0] r, f;
    rr_q.delete();
    rf_q.delete();
    cs_on();
    foreach (tx_q[i]) begin
      xbyte(tx_q[i], r, f);
      rr_q.push_back(r);
      rf_q.push_back(f);
    end
    cs_off();
    tx_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic sr, sf;
    logic [7:0] r, f, acc;

    clks(3);
    rst = 1'b0;
    clks(2);
    check("rst_miso", 8'(miso_r), 8'h00);
    check("rst_busy", 8'(busy_r), 8'h00);
    check("rst_last_cmd", last_r, 8'h00);

    load(12'h010, 8'hA5); load(12'h011, 8'h5A);
    load(12'h012, 8'h01); load(12'h013, 8'hFF);
    load(12'hFFF, 8'h11); load(12'h000, 8'h22);
    load(12'h100, 8'h33); load(12'h101, 8'h44);

    // Basic READ of four bytes.
    put_hdr(8'h03, 16'h0010); repeat (4) put(8'h00);
    run_txn();
    check("rd_addr_phase_miso", rr_q[2], 8'h00);
    check("rd_b0", rr_q[3], 8'hA5);
    check("rd_b1", rr_q[4], 8'h5A);
    check("rd_b2", rr_q[5], 8'h01);
    check("rd_b3", rr_q[6], 8'hFF);
    check("rd_last_cmd", last_r, 8'h03);
    check("rd_busy_after", 8'(busy_r), 8'h00);

    // Address wraps at DEPTH.
    put_hdr(8'h03, 16'h0FFF); put(8'h00); put(8'h00);
    run_txn();
    check("wrap_b0", rr_q[3], 8'h11);
    check("wrap_b1", rr_q[4], 8'h22);

    // Address bits above clog2(DEPTH) ignored: 0xF010 -> 0x010.
    put_hdr(8'h03, 16'hF010); put(8'h00);
    run_txn();
    check("addr_mod", rr_q[3], 8'hA5);

    // WRITE then READ back: RAM takes the data, flash keeps the preload.
    put_hdr(8'h02, 16'h0100); put(8'hDE); put(8'hAD);
    run_txn();
    check("wr_last_cmd", last_r, 8'h02);
    put_hdr(8'h03, 16'h0100); put(8'h00); put(8'h00);
    run_txn();
    check("ram_wr_b0", rr_q[3], 8'hDE);
    check("ram_wr_b1", rr_q[4], 8'hAD);
    check("flash_wr_b0", rf_q[3], 8'h33);
    check("flash_wr_b1", rf_q[4], 8'h44);
    check("flash_last_cmd", last_f, 8'h03);

    // FAST_READ: MISO low through the dummy byte, then data.
    put_hdr(8'h0B, 16'h0010); put(8'h00); put(8'h00); put(8'h00);
    run_txn();
    check("fast_dummy", rr_q[3], 8'h00);
    check("fast_b0", rr_q[4], 8'hA5);
    check("fast_b1", rr_q[5], 8'h5A);

    // WRITE aborted after 4 data bits: byte untouched, busy drops within 3 clk.
    cs_on();
    xbyte(8'h02, r, f); xbyte(8'h01, r, f); xbyte(8'h00, r, f);
    for (int i = 0; i < 4; i++) xbit(1'b0, sr, sf);
    check("abort_busy_before", 8'(busy_r), 8'h01);
    ce_n = 1'b1;
    clks(3);
    check("abort_busy_after", 8'(busy_r), 8'h00);
    clks(3);
    put_hdr(8'h03, 16'h0100); put(8'h00);
    run_txn();
    check("abort_byte_kept", rr_q[3], 8'hDE);

    // Unknown command is ignored with MISO held low.
    cs_on();
    xbyte(8'h9F, r, f);
    acc = 8'h00;
    for (int i = 0; i < 3; i++) begin
      xbyte(8'hFF, r, f);
      acc = acc | r;
    end
    check("ign_busy", 8'(busy_r), 8'h01);
    cs_off();
    check("ign_miso", acc, 8'h00);
    check("ign_last_cmd", last_r, 8'h9F);

    // SCK toggling with CE_N high has no effect.
    for (int i = 0; i < 8; i++) xbit(1'b1, sr, sf);
    check("idle_sck_busy", 8'(busy_r), 8'h00);
    check("idle_sck_last_cmd", last_r, 8'h9F);

    // Reset mid-READ while MISO is driving the MSB of 0xA5.
    cs_on();
    xbyte(8'h03, r, f); xbyte(8'h00, r, f); xbyte(8'h10, r, f);
    mosi = 1'b0;
    clks(hp);
    sck = 1'b1;
    clks(hp);
    check("mid_rd_miso", 8'(miso_r), 8'h01);
    rst = 1'b1;
    #1;
    check("arst_miso", 8'(miso_r), 8'h00);
    check("arst_busy", 8'(busy_r), 8'h00);
    check("arst_last_cmd", last_r, 8'h00);
    @(negedge clk);
    sck = 1'b0;
    ce_n = 1'b1;
    clks(3);
    rst = 1'b0;
    clks(4);
    put_hdr(8'h03, 16'h0011); put(8'h00); put(8'h00);
    run_txn();
    check("post_rst_b0", rr_q[3], 8'h5A);
    check("post_rst_b1", rr_q[4], 8'h01);

    // Slow SCK: 1:16 ratio.
    hp = 8;
    put_hdr(8'h03, 16'h0010); repeat (4) put(8'h00);
    run_txn();
    check("slow_b0", rr_q[3], 8'hA5);
    check("slow_b1", rr_q[4], 8'h5A);
    check("slow_b2", rr_q[5], 8'h01);
    check("slow_b3", rr_q[6], 8'hFF);
    put_hdr(8'h0B, 16'h0012); put(8'h00); put(8'h00); put(8'h00);
    run_txn();
    check("slow_fast_dummy", rr_q[3], 8'h00);
    check("slow_fast_b0", rr_q[4], 8'h01);
    check("slow_fast_b1", rr_q[5], 8'hFF);
    check("slow_flash_busy", 8'(busy_f), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
